// File: rtl/mac_frame_enc.sv
// rtl/mac_frame_enc.sv - transmit-side Ethernet frame assembler
//
// Pops one header word and its body bytes and writes one complete frame
// into the TX packet FIFO: preamble, SFD, dst, src, ethertype, body,
// zero pad up to MIN_PAYLOAD, and optionally the FCS. The final byte
// carries o_fifo_del.
//
// Optional feature macro: MAC_FRAME_ENC_FCS_EN
//   defined   - CRC-32 logic and the FCS state are built; EOD is on the 4th FCS byte
//   undefined - no CRC; EOD is on the last body/pad byte, the PHY appends the FCS
//
// Ports:
//   clk, arst_n                       clock, asynchronous active-low reset
//   h_fifo_dout/empty/rden            header FIFO (dout valid the cycle after rden)
//   b_fifo_dout/empty/del/rden        body FIFO (dout/del valid the cycle after rden)
//   o_fifo_din/wren/del, o_fifo_afull TX packet FIFO write side
//   busy                              high whenever the FSM is not IDLE
module mac_frame_enc #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 46,
  parameter int HDR_W        = 115
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [HDR_W-1:0] h_fifo_dout,
  input  logic             h_fifo_empty,
  output logic             h_fifo_rden,
  input  logic [7:0]       b_fifo_dout,
  input  logic             b_fifo_empty,
  input  logic             b_fifo_del,
  output logic             b_fifo_rden,
  output logic [7:0]       o_fifo_din,
  output logic             o_fifo_wren,
  output logic             o_fifo_del,
  input  logic             o_fifo_afull,
  output logic             busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PRE  = 3'd2;
  localparam logic [2:0] S_MAC  = 3'd3;
  localparam logic [2:0] S_BODY = 3'd4;
  localparam logic [2:0] S_PAD  = 3'd5;
`ifdef MAC_FRAME_ENC_FCS_EN
  localparam logic [2:0] S_FCS  = 3'd6;
`endif

  logic [2:0]       state, state_n;
  logic [3:0]       cnt;
  logic [10:0]      paylen, paylen_inc;
  logic [HDR_W-1:0] hdr_sr;
  logic             run;
  logic             rd_pend, hold_v, hold_del, cur_del, byte_avail, short_body;
  logic [7:0]       hold_byte, cur_byte;
`ifdef MAC_FRAME_ENC_FCS_EN
  logic [31:0]      crc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction
`endif

  assign busy = (state != S_IDLE);

  always_comb begin
    state_n     = state;
    o_fifo_din  = 8'h00;
    o_fifo_wren = 1'b0;
    o_fifo_del  = 1'b0;
    h_fifo_rden = 1'b0;
    b_fifo_rden = 1'b0;
    // The body byte is taken straight from the FIFO the cycle after the
    // read; if the TX FIFO is full that cycle it is parked in hold_byte.
    cur_byte    = rd_pend ? b_fifo_dout : hold_byte;
    cur_del     = rd_pend ? b_fifo_del : hold_del;
    byte_avail  = rd_pend | hold_v;
    paylen_inc  = (paylen == '1) ? paylen : paylen + 11'd1;
    short_body  = (paylen_inc < 11'(MIN_PAYLOAD));
    case (state)
      S_IDLE: begin
        if (run && !h_fifo_empty) begin
          h_fifo_rden = 1'b1;
          state_n     = S_HDR;
        end
      end
      S_HDR: state_n = S_PRE;
      S_PRE: begin
        o_fifo_din  = (cnt == 4'(PREAMBLE_LEN)) ? 8'hD5 : 8'h55;
        o_fifo_wren = !o_fifo_afull;
        if (o_fifo_wren && cnt == 4'(PREAMBLE_LEN)) state_n = S_MAC;
      end
      S_MAC: begin
        o_fifo_din  = hdr_sr[HDR_W-1 -: 8];
        o_fifo_wren = !o_fifo_afull;
        if (o_fifo_wren && cnt == 4'd13) state_n = S_BODY;
      end
      S_BODY: begin
        o_fifo_din  = cur_byte;
        o_fifo_wren = byte_avail && !o_fifo_afull;
        b_fifo_rden = !byte_avail && !b_fifo_empty && !o_fifo_afull;
        if (o_fifo_wren && cur_del) begin
          if (short_body) begin
            state_n = S_PAD;
          end else begin
`ifdef MAC_FRAME_ENC_FCS_EN
            state_n = S_FCS;
`else
            state_n    = S_IDLE;
            o_fifo_del = 1'b1;
`endif
          end
        end
      end
      S_PAD: begin
        o_fifo_wren = !o_fifo_afull;
        if (o_fifo_wren && !short_body) begin
`ifdef MAC_FRAME_ENC_FCS_EN
          state_n = S_FCS;
`else
          state_n    = S_IDLE;
          o_fifo_del = 1'b1;
`endif
        end
      end
`ifdef MAC_FRAME_ENC_FCS_EN
      S_FCS: begin
        // crc is shifted right a byte per write, so the low byte is always next
        o_fifo_din  = ~crc[7:0];
        o_fifo_wren = !o_fifo_afull;
        if (o_fifo_wren && cnt == 4'd3) begin
          o_fifo_del = 1'b1;
          state_n    = S_IDLE;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      paylen    <= 11'd0;
      hdr_sr    <= '0;
      run       <= 1'b0;
      rd_pend   <= 1'b0;
      hold_v    <= 1'b0;
      hold_del  <= 1'b0;
      hold_byte <= 8'h00;
`ifdef MAC_FRAME_ENC_FCS_EN
      crc       <= 32'h0;
`endif
    end else begin
      // run keeps the header pop off until the first clock after reset
      run     <= 1'b1;
      state   <= state_n;
      rd_pend <= b_fifo_rden;
      if (state == S_HDR) begin
        hdr_sr <= h_fifo_dout;
        cnt    <= 4'd0;
        paylen <= 11'd0;
        hold_v <= 1'b0;
`ifdef MAC_FRAME_ENC_FCS_EN
        crc    <= 32'hFFFFFFFF;
`endif
      end
      if (state == S_BODY && byte_avail) begin
        if (o_fifo_wren) begin
          hold_v <= 1'b0;
        end else begin
          hold_v    <= 1'b1;
          hold_byte <= cur_byte;
          hold_del  <= cur_del;
        end
      end
      if (o_fifo_wren) begin
        case (state)
          S_PRE:  cnt <= (cnt == 4'(PREAMBLE_LEN)) ? 4'd0 : cnt + 4'd1;
          S_MAC: begin
            hdr_sr <= {hdr_sr[HDR_W-9:0], 8'h00};
            cnt    <= (cnt == 4'd13) ? 4'd0 : cnt + 4'd1;
          end
          S_BODY, S_PAD: paylen <= paylen_inc;
`ifdef MAC_FRAME_ENC_FCS_EN
          S_FCS:  cnt <= cnt + 4'd1;
`endif
          default: ;
        endcase
`ifdef MAC_FRAME_ENC_FCS_EN
        if (state == S_MAC || state == S_BODY || state == S_PAD)
          crc <= crc_byte(crc, o_fifo_din);
        else if (state == S_FCS)
          crc <= {8'h00, crc[31:8]};
`endif
      end
    end
  end

endmodule

// File: tb/tb_mac_frame_enc.sv
// tb/tb_mac_frame_enc.sv - self-checking bench for mac_frame_enc
module tb_mac_frame_enc;

`ifdef MAC_FRAME_ENC_FCS_EN
  localparam int FCS_N = 4;
`else
  localparam int FCS_N = 0;
`endif

  logic         clk = 1'b0;
  logic         arst_n = 1'b0;
  logic [114:0] h_fifo_dout = '0;
  logic         h_fifo_empty = 1'b1;
  logic         h_fifo_rden;
  logic [7:0]   b_fifo_dout = 8'h00;
  logic         b_fifo_empty = 1'b1;
  logic         b_fifo_del = 1'b0;
  logic         b_fifo_rden;
  logic [7:0]   o_fifo_din;
  logic         o_fifo_wren;
  logic         o_fifo_del;
  logic         o_fifo_afull = 1'b0;
  logic         busy;

  mac_frame_enc dut (
    .clk(clk), .arst_n(arst_n),
    .h_fifo_dout(h_fifo_dout), .h_fifo_empty(h_fifo_empty), .h_fifo_rden(h_fifo_rden),
    .b_fifo_dout(b_fifo_dout), .b_fifo_empty(b_fifo_empty), .b_fifo_del(b_fifo_del),
    .b_fifo_rden(b_fifo_rden),
    .o_fifo_din(o_fifo_din), .o_fifo_wren(o_fifo_wren), .o_fifo_del(o_fifo_del),
    .o_fifo_afull(o_fifo_afull), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [114:0] hq[$];
  logic [8:0]   bq[$];
  logic [8:0]   expq[$];
  int n_chk = 0, n_err = 0, cyc = 0, n_wr = 0, n_eod = 0;
  int hrden_cyc = 0, first_wr_cyc = 0, frame_idx = 0;
  bit first_pend = 0, in_frame = 0, throttle = 0;
  logic [31:0] mon_crc = 32'hFFFFFFFF;

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++)
      r = (r[0] ^ d[k]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Source FIFOs, TX sink, scoreboard and protocol monitor, one step per cycle
  always @(negedge clk) begin
    logic [8:0] e;
    h_fifo_empty = (hq.size() == 0);
    b_fifo_empty = (bq.size() == 0);
    o_fifo_afull = throttle ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    cyc++;
    if (!arst_n) begin
      in_frame   = 0;
      first_pend = 0;
      frame_idx  = 0;
      mon_crc    = 32'hFFFFFFFF;
    end else begin
      if (h_fifo_rden) begin
        n_chk++;
        if (in_frame) begin
          n_err++;
          $display("FAIL hdr_pop_overlap got pop at cycle %0d want none before EOD", cyc);
        end
        in_frame = 1; hrden_cyc = cyc; first_pend = 1;
        if (hq.size() > 0) h_fifo_dout = hq.pop_front();
      end
      if (b_fifo_rden && bq.size() > 0) {b_fifo_del, b_fifo_dout} = bq.pop_front();
      if (o_fifo_afull) begin
        n_chk++;
        if (o_fifo_wren) begin
          n_err++;
          $display("FAIL wren_while_afull got wren=1 want 0 at cycle %0d", cyc);
        end
      end
      if (o_fifo_wren) begin
        n_wr++;
        if (first_pend) begin first_wr_cyc = cyc; first_pend = 0; end
        n_chk++;
        if (expq.size() == 0) begin
          n_err++;
          $display("FAIL extra_write got din=%02h del=%0b want no write", o_fifo_din, o_fifo_del);
        end else begin
          e = expq.pop_front();
          if ({o_fifo_del, o_fifo_din} !== e) begin
            n_err++;
            $display("FAIL stream_byte got del=%0b din=%02h want del=%0b din=%02h",
                     o_fifo_del, o_fifo_din, e[8], e[7:0]);
          end
        end
        if (frame_idx >= 8) mon_crc = crc8(mon_crc, o_fifo_din);
        frame_idx++;
        if (o_fifo_del) begin
          n_eod++;
          in_frame = 0;
`ifdef MAC_FRAME_ENC_FCS_EN
          n_chk++;
          if (mon_crc !== 32'hDEBB20E3) begin
            n_err++;
            $display("FAIL crc_residue got %08h want DEBB20E3", mon_crc);
          end
`endif
          frame_idx = 0;
          mon_crc   = 32'hFFFFFFFF;
        end
      end
    end
  end

  task automatic queue_frame(input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] et, input int len, input bit rnd);
    logic [8:0]   q[$];
    logic [111:0] mac;
    logic [7:0]   b;
    logic [31:0]  c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) q.push_back({1'b0, 8'h55});
    q.push_back({1'b0, 8'hD5});
    mac = {dst, src, et};
    for (int i = 0; i < 14; i++) begin
      b = mac[111-8*i -: 8]; c = crc8(c, b); q.push_back({1'b0, b});
    end
    for (int i = 0; i < len; i++) begin
      b = rnd ? 8'($urandom) : 8'(i);
      c = crc8(c, b);
      q.push_back({1'b0, b});
      bq.push_back({(i == len - 1), b});
    end
    for (int i = len; i < 46; i++) begin
      c = crc8(c, 8'h00); q.push_back(9'h000);
    end
`ifdef MAC_FRAME_ENC_FCS_EN
    c = ~c;
    for (int i = 0; i < 4; i++) q.push_back({1'b0, c[8*i +: 8]});
`endif
    for (int i = 0; i < q.size(); i++)
      expq.push_back({(i == q.size() - 1), q[i][7:0]});
    hq.push_back({dst, src, et, 3'b101});
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while ((expq.size() != 0 || hq.size() != 0 || busy) && k < budget) begin
      @(negedge clk); #2; k++;
    end
    n_chk++;
    if (k >= budget) begin
      n_err++;
      $display("FAIL timeout_%s got %0d cycles want < %0d (exp left %0d)", name, k, budget, expq.size());
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] etype;
    int          len;
    bit          rnd;
    bit          thr;
    int          exp_wr;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int w0, e0, len, k;
    vecs[0] = '{48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800, 60,   0, 0, 82 + FCS_N};
    vecs[1] = '{48'h001122334455, 48'h020000000001, 16'h0800, 10,   0, 0, 68 + FCS_N};
    vecs[2] = '{48'hA1B2C3D4E5F6, 48'h665544332211, 16'h86DD, 1,    1, 0, 68 + FCS_N};
    vecs[3] = '{48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0806, 46,   1, 0, 68 + FCS_N};
    vecs[4] = '{48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0806, 45,   1, 1, 68 + FCS_N};
    vecs[5] = '{48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800, 60,   0, 1, 82 + FCS_N};
    vecs[6] = '{48'h5A5A5A5A5A5A, 48'hC3C3C3C3C3C3, 16'h88B5, 47,   1, 1, 69 + FCS_N};
    vecs[7] = '{48'h123456789ABC, 48'hDEF012345678, 16'h0800, 1500, 1, 0, 1522 + FCS_N};

    repeat (3) @(negedge clk);
    #2;
    check_int("reset_outputs",
              int'({o_fifo_wren, o_fifo_del, o_fifo_din, h_fifo_rden, b_fifo_rden, busy}), 0);
    #1 arst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      throttle = vecs[i].thr;
      w0 = n_wr; e0 = n_eod;
      queue_frame(vecs[i].dst, vecs[i].src, vecs[i].etype, vecs[i].len, vecs[i].rnd);
      wait_done(20000, $sformatf("vec%0d", i));
      check_int($sformatf("writes_vec%0d", i), n_wr - w0, vecs[i].exp_wr);
      check_int($sformatf("eod_vec%0d", i), n_eod - e0, 1);
      if (i == 0) check_int("hdr_to_first_write_latency", first_wr_cyc - hrden_cyc, 2);
    end

    for (int i = 0; i < 3; i++) begin
      len = $urandom_range(1, 1500);
      throttle = (i == 1);
      w0 = n_wr; e0 = n_eod;
      queue_frame(48'h0000DEADBEEF, 48'h020000000002, 16'h0800, len, 1);
      wait_done(20000, $sformatf("rnd%0d", i));
      check_int($sformatf("writes_rnd%0d_len%0d", i, len), n_wr - w0,
                22 + ((len < 46) ? 46 : len) + FCS_N);
      check_int($sformatf("eod_rnd%0d", i), n_eod - e0, 1);
    end

    // Reset in the middle of the body of frame A, then frames B and C
    throttle = 1'b0;
    w0 = n_wr;
    queue_frame(48'hAAAAAAAAAAAA, 48'h020000000003, 16'h0800, 100, 0);
    k = 0;
    while ((n_wr - w0) < 30 && k < 2000) begin @(negedge clk); #2; k++; end
    check_int("frameA_reaches_body", ((n_wr - w0) >= 30) ? 1 : 0, 1);
    #1 arst_n = 1'b0;
    hq.delete(); bq.delete(); expq.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      check_int($sformatf("outputs_in_reset_%0d", i),
                int'({o_fifo_wren, o_fifo_del, o_fifo_din, h_fifo_rden, b_fifo_rden, busy}), 0);
    end
    @(negedge clk); #3 arst_n = 1'b1;
    w0 = n_wr; e0 = n_eod;
    queue_frame(48'hBBBBBBBBBBBB, 48'h020000000004, 16'h0800, 20, 1);
    queue_frame(48'hCCCCCCCCCCCC, 48'h020000000005, 16'h0806, 50, 1);
    wait_done(20000, "frames_bc");
    check_int("writes_bc", n_wr - w0, 68 + FCS_N + 72 + FCS_N);
    check_int("eod_bc", n_eod - e0, 2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
